// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: round-robin producer arbiter and reader scheduler for one shared FIFO.
// It issues at most one FIFO strobe per cycle. A burst counter forces a read after MAX_BURST writes.
`timescale 1ns/1ps
module fifo_rr_scheduler #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din_bus,
    output logic [NREQ-1:0]    ack,
    output logic [2:0]         grant_id,
    input  logic               rd_req,
    output logic               rd_valid,
    output logic [DW-1:0]      rd_data,
    output logic               fifo_wr,
    output logic               fifo_rd,
    output logic [DW-1:0]      fifo_din,
    input  logic [DW-1:0]      fifo_dout,
    input  logic               fifo_full,
    input  logic               fifo_empty
);
    localparam int unsigned PW   = $clog2(NREQ);
    localparam logic [3:0]  BMAX = 4'(MAX_BURST);

    typedef enum logic [1:0] {OP_IDLE, OP_WRITE, OP_READ} op_t;

    logic [PW-1:0] r_ptr;
    logic [3:0]    r_bcnt;
    logic          r_rd_valid;
    logic [DW-1:0] r_rd_data;

    logic          w_wok;
    logic          w_rok;
    op_t           w_op;
    logic          w_found;
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_winner;
    logic [PW:0]   w_nxt_sum;
    logic [PW-1:0] w_ptr_nxt;

    // Scan req starting at r_ptr and wrap modulo NREQ. The first requester found wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NREQ))
                w_sum = w_sum - (PW+1)'(NREQ);
            if (!w_found && req[w_sum[PW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[PW-1:0];
            end
        end
        w_nxt_sum = {1'b0, w_winner} + (PW+1)'(1);
        w_ptr_nxt = (w_nxt_sum == (PW+1)'(NREQ)) ? '0 : w_nxt_sum[PW-1:0];
    end

    // r_bcnt saturates at BMAX. Once both sides are eligible, reaching BMAX hands the cycle to the reader.
    always_comb begin
        w_wok = w_found && !fifo_full;
        w_rok = rd_req && !fifo_empty;
        if (rst)
            w_op = OP_IDLE;
        else if (w_wok && (!w_rok || r_bcnt < BMAX))
            w_op = OP_WRITE;
        else if (w_rok)
            w_op = OP_READ;
        else
            w_op = OP_IDLE;
    end

    always_comb begin
        fifo_wr  = (w_op == OP_WRITE);
        fifo_rd  = (w_op == OP_READ);
        ack      = fifo_wr ? (NREQ'(1) << w_winner) : '0;
        grant_id = fifo_wr ? 3'(w_winner) : 3'd0;
        fifo_din = din_bus[w_winner*DW +: DW];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_bcnt     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= (w_op == OP_READ);
            if (w_op == OP_READ)
                r_rd_data <= fifo_dout;
            if (w_op == OP_WRITE)
                r_ptr <= w_ptr_nxt;
            if (!w_rok || w_op == OP_READ)
                r_bcnt <= '0;
            else if (w_op == OP_WRITE && r_bcnt < BMAX)
                r_bcnt <= r_bcnt + 4'd1;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler. It uses a behavioural 8x16 FIFO with write priority and head-of-queue dout,
// and a read-data scoreboard queue.
`timescale 1ns/1ps
module tb_fifo_rr_scheduler;
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] din_bus;
    logic [NREQ-1:0]    ack;
    logic [2:0]         grant_id;
    logic               rd_req;
    logic               rd_valid;
    logic [DW-1:0]      rd_data;
    logic               fifo_wr;
    logic               fifo_rd;
    logic [DW-1:0]      fifo_din;
    logic [DW-1:0]      fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;

    logic [DW-1:0] pdata [NREQ];
    logic [DW-1:0] sb [$];
    logic          exp_rdv;
    logic          drop;
    int            n_checks;
    int            n_errors;

    fifo_rr_scheduler #(.NREQ(NREQ), .DW(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .din_bus(din_bus), .ack(ack),
        .grant_id(grant_id), .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
        .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_din(fifo_din), .fifo_dout(fifo_dout),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    // Behavioural FIFO model: 16 entries; a write takes priority over a read in the same cycle.
    logic [DW-1:0] fmem [16];
    logic [3:0]    fwp;
    logic [3:0]    frp;
    logic [4:0]    fcnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fwp  <= '0;
            frp  <= '0;
            fcnt <= '0;
        end else if (fifo_wr && fcnt != 5'd16) begin
            fmem[fwp] <= fifo_din;
            fwp       <= fwp + 4'd1;
            fcnt      <= fcnt + 5'd1;
        end else if (fifo_rd && fcnt != 5'd0) begin
            frp  <= frp + 4'd1;
            fcnt <= fcnt - 5'd1;
        end
    end

    assign fifo_dout  = fmem[frp];
    assign fifo_full  = (fcnt == 5'd16);
    assign fifo_empty = (fcnt == 5'd0);

    always_comb begin
        din_bus = '0;
        for (int i = 0; i < NREQ; i++)
            din_bus[i*DW +: DW] = pdata[i];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks();
        @(negedge clk);
        check("rst_fifo_wr",  32'(fifo_wr),  32'd0);
        check("rst_fifo_rd",  32'(fifo_rd),  32'd0);
        check("rst_ack",      32'(ack),      32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data",  32'(rd_data),  32'd0);
    endtask

    // One clock cycle: check the strobes against the expected op, then advance past the edge.
    task automatic tick(input logic ewr, input logic erd, input int egid);
        logic [NREQ-1:0] eack;
        logic [DW-1:0]   edata;
        @(negedge clk);
        eack = ewr ? (NREQ'(1) << egid) : '0;
        check("fifo_wr", 32'(fifo_wr), 32'(ewr));
        check("fifo_rd", 32'(fifo_rd), 32'(erd));
        check("ack",     32'(ack),     32'(eack));
        if (ewr) begin
            check("grant_id", 32'(grant_id), 32'(egid));
            check("fifo_din", 32'(fifo_din), 32'(pdata[egid]));
            sb.push_back(pdata[egid]);
        end
        check("rd_valid", 32'(rd_valid), 32'(exp_rdv));
        if (exp_rdv) begin
            edata = (sb.size() != 0) ? sb.pop_front() : 'x;
            check("rd_data", 32'(rd_data), 32'(edata));
        end
        exp_rdv = erd;
        @(posedge clk);
        #1;
        if (drop)
            req = req & ~eack;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_rdv  = 1'b0;
        drop     = 1'b0;
        rst      = 1'b1;
        req      = '1;
        rd_req   = 1'b1;
        pdata[0] = 8'h10;
        pdata[1] = 8'h11;
        pdata[2] = 8'h12;
        pdata[3] = 8'h13;
        reset_checks();
        @(posedge clk);
        #1;

        // Test 1: four producers write in round-robin order, then the data is read back.
        rst    = 1'b0;
        rd_req = 1'b0;
        req    = 4'b1111;
        drop   = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, i);
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 0);

        // Test 2: producer 0 fills the FIFO with 00..0F, then it is held off while full.
        rd_req   = 1'b0;
        drop     = 1'b0;
        pdata[0] = 8'h00;
        req      = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b0, 0);
            pdata[0] = pdata[0] + 8'd1;
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 0);
        req    = '0;
        rd_req = 1'b1;
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 0);

        // Test 3: producers 0 and 2 alternate. The pointer was left at 1, so producer 2 goes first.
        rd_req   = 1'b0;
        pdata[0] = 8'h30;
        pdata[2] = 8'h32;
        req      = 4'b0101;
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, (i % 2 == 0) ? 2 : 0);
        req    = '0;
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 0);

        // Test 4: two entries are left; a held writer plus a reader gives WR x4 then RD.
        pdata[1] = 8'h41;
        req      = 4'b0010;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1);
            tick(1'b0, 1'b1, 0);
        end

        // Test 6: reset mid-burst clears everything, and arbitration restarts at producer 0.
        rst = 1'b1;
        reset_checks();
        @(posedge clk);
        #1;
        reset_checks();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_rdv  = 1'b0;
        rd_req   = 1'b0;
        pdata[0] = 8'h60;
        pdata[3] = 8'h63;
        req      = 4'b1001;
        drop     = 1'b1;
        tick(1'b1, 1'b0, 0);
        tick(1'b1, 1'b0, 3);

        // Test 5: drain to empty; no read while empty; one write makes a read eligible next cycle.
        req    = '0;
        rd_req = 1'b1;
        tick(1'b0, 1'b1, 0);
        tick(1'b0, 1'b1, 0);
        tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        pdata[2] = 8'hA5;
        req      = 4'b0100;
        tick(1'b1, 1'b0, 2);
        tick(1'b0, 1'b1, 0);
        tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
